sram_ctrl: RTL and testbench

- Sequencer directly upstream of the on-chip SRAM.
- Accepts single-word read/write requests from a bus master over a req/ack handshake.
- Drives the SRAM's addr/idata/cs_/rw_ pins from registers and captures the SRAM's combinational odata into a held read-data register.
- Also contains an init engine that sweeps every SRAM address with a fixed fill value after power-up or on command.

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_ctrl.sv | 130 +++++++++++++
 tb/tb_sram_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants, pin encodings and FSM state type for the SRAM sequencer.
package sram_ctrl_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 8;
  localparam int unsigned DATA_WIDTH     = 32;

  // SRAM control pins are active-low: cs_ low enables, rw_ low writes.
  localparam logic CS_ENABLE  = 1'b0;
  localparam logic CS_DISABLE = 1'b1;
  localparam logic RW_READ    = 1'b1;
  localparam logic RW_WRITE   = 1'b0;

  typedef enum logic [1:0] {
    SC_IDLE   = 2'd0,
    SC_ACCESS = 2'd1,
    SC_RESP   = 2'd2,
    SC_INIT   = 2'd3
  } sc_state_e;

  function automatic logic rw_of(input logic we);
    return we ? RW_WRITE : RW_READ;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-word req/ack sequencer in front of the on-chip SRAM, with a
// fill engine that sweeps every address with INIT_VALUE on command.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = MEM_ADDR_WIDTH,
  parameter int unsigned       DATA_W     = DATA_WIDTH,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  input  logic              init_start,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_idata,
  input  logic [DATA_W-1:0] mem_odata,
  output logic              mem_cs_,
  output logic              mem_rw_
);

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  sc_state_e         state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_idata_d;
  logic              cs_d, rw_d;
  logic [DATA_W-1:0] rdata_d;
  logic              ack_d, rvalid_d, init_done_d, busy_d;

  // Next-state and next-output logic; every pin register is recomputed each cycle.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    mem_addr_d  = mem_addr;
    mem_idata_d = mem_idata;
    cs_d        = CS_DISABLE;
    rw_d        = RW_READ;
    rdata_d     = rdata;
    ack_d       = 1'b0;
    rvalid_d    = 1'b0;
    init_done_d = 1'b0;

    unique case (state)
      SC_IDLE: begin
        if (init_start) begin
          state_d     = SC_INIT;
          cnt_d       = '0;
          mem_addr_d  = '0;
          mem_idata_d = INIT_VALUE;
          cs_d        = CS_ENABLE;
          rw_d        = RW_WRITE;
        end else if (req) begin
          state_d     = SC_ACCESS;
          mem_addr_d  = addr;
          mem_idata_d = wdata;
          cs_d        = CS_ENABLE;
          rw_d        = rw_of(we);
        end
      end
      SC_ACCESS: begin
        state_d  = SC_RESP;
        ack_d    = 1'b1;
        rvalid_d = (mem_rw_ == RW_READ);
        if (mem_rw_ == RW_READ) begin
          rdata_d = mem_odata;
        end
      end
      SC_RESP: begin
        state_d = SC_IDLE;
      end
      SC_INIT: begin
        // The write of mem_addr == cnt commits at this edge; stop after the top address.
        if (cnt == CNT_MAX) begin
          state_d     = SC_IDLE;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d       = cnt + ADDR_W'(1);
          mem_addr_d  = cnt + ADDR_W'(1);
          mem_idata_d = INIT_VALUE;
          cs_d        = CS_ENABLE;
          rw_d        = RW_WRITE;
        end
      end
      default: begin
        state_d = SC_IDLE;
      end
    endcase

    busy_d = (state_d != SC_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state     <= SC_IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_idata <= '0;
      mem_cs_   <= CS_DISABLE;
      mem_rw_   <= RW_READ;
      rdata     <= '0;
      ack       <= 1'b0;
      rvalid    <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      mem_addr  <= mem_addr_d;
      mem_idata <= mem_idata_d;
      mem_cs_   <= cs_d;
      mem_rw_   <= rw_d;
      rdata     <= rdata_d;
      ack       <= ack_d;
      rvalid    <= rvalid_d;
      init_done <= init_done_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural SRAM and a word-array reference model.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam logic [DW-1:0] INIT_V = '0;

  logic          clk, reset_, req, we, init_start;
  logic [AW-1:0] addr, mem_addr;
  logic [DW-1:0] wdata, rdata, mem_idata, mem_odata;
  logic          ack, rvalid, busy, init_done, mem_cs_, mem_rw_;

  logic [DW-1:0] sram [DEPTH];
  assign mem_odata = sram[mem_addr];
  always @(posedge clk)
    if (mem_cs_ == CS_ENABLE && mem_rw_ == RW_WRITE) sram[mem_addr] <= mem_idata;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INIT_VALUE(INIT_V)) dut (
    .clk(clk), .reset_(reset_), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .rvalid(rvalid), .busy(busy),
    .init_start(init_start), .init_done(init_done),
    .mem_addr(mem_addr), .mem_idata(mem_idata), .mem_odata(mem_odata),
    .mem_cs_(mem_cs_), .mem_rw_(mem_rw_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_access = 0;
  int ack_seen = 0;
  int bad_inv  = 0;

  logic [DW-1:0] rm [DEPTH];
  logic [DW-1:0] rd_exp;

  // Handshake invariants observed every cycle.
  always @(negedge clk) begin
    if (ack) ack_seen <= ack_seen + 1;
    if (rvalid && !ack) bad_inv <= bad_inv + 1;
    if (ack && mem_cs_ == CS_ENABLE) bad_inv <= bad_inv + 1;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // One request issued from IDLE; checks the ACCESS, RESP and following IDLE cycles.
  task automatic do_access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic exp_rv, input logic [DW-1:0] exp_rd);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    check("acc_cs", 32'(mem_cs_), 32'(CS_ENABLE));
    check("acc_addr", 32'(mem_addr), 32'(a));
    check("acc_rw", 32'(mem_rw_), 32'(w ? RW_WRITE : RW_READ));
    check("acc_noack", 32'(ack), 32'd0);
    if (w) check("acc_idata", mem_idata, d);
    @(negedge clk);
    check("resp_ack", 32'(ack), 32'd1);
    check("resp_rvalid", 32'(rvalid), 32'(exp_rv));
    check("resp_rdata", rdata, exp_rd);
    check("resp_cs", 32'(mem_cs_), 32'(CS_DISABLE));
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    check("idle_ack", 32'(ack), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    n_access++;
  endtask

  task automatic model_access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (w) rm[a] = d;
    else   rd_exp = rm[a];
    do_access(w, a, d, !w, rd_exp);
  endtask

  // Full fill sweep; returns at the cycle where init_done should be high.
  task automatic run_sweep();
    int good;
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    good = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (mem_cs_ == CS_ENABLE && mem_rw_ == RW_WRITE && mem_addr == AW'(i) &&
          mem_idata == INIT_V && busy && !init_done && !ack)
        good++;
      @(negedge clk);
    end
    check("sweep_cycles", 32'(good), 32'(DEPTH));
    check("sweep_done", 32'(init_done), 32'd1);
    check("sweep_busy_end", 32'(busy), 32'd0);
    check("sweep_cs_end", 32'(mem_cs_), 32'(CS_DISABLE));
    check("sweep_rdata_kept", rdata, rd_exp);
    for (int i = 0; i < int'(DEPTH); i++) rm[i] = INIT_V;
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rv;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int en;
    tbl[0] = '{1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 8'h12, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 8'h34, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 8'h34, 32'h0,        1'b1, 32'hCAFEF00D};
    tbl[4] = '{1'b0, 8'h12, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[5] = '{1'b0, 8'h00, 32'h0,        1'b1, 32'h0};
    tbl[6] = '{1'b0, 8'h7F, 32'h0,        1'b1, 32'h0};
    tbl[7] = '{1'b0, 8'hFF, 32'h0,        1'b1, 32'h0};
    tbl[8] = '{1'b1, 8'h05, 32'h5555AAAA, 1'b0, 32'h0};
    tbl[9] = '{1'b0, 8'h12, 32'h0,        1'b1, 32'hDEADBEEF};

    reset_ = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; init_start = 1'b0;
    rd_exp = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs", 32'(mem_cs_), 32'(CS_DISABLE));
    check("rst_rw", 32'(mem_rw_), 32'(RW_READ));
    check("rst_maddr", 32'(mem_addr), 32'd0);
    check("rst_midata", mem_idata, 32'd0);
    reset_ = 1'b1;
    @(negedge clk);

    run_sweep();
    @(negedge clk);
    check("sweep_done_pulse", 32'(init_done), 32'd0);

    for (int k = 0; k < 10; k++) begin
      if (tbl[k].w) rm[tbl[k].a] = tbl[k].d;
      rd_exp = tbl[k].rd;
      do_access(tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].rv, tbl[k].rd);
    end

    // init_start and a read of 0x05 together: the sweep runs first, then the read.
    req = 1'b1; we = 1'b0; addr = 8'h05;
    run_sweep();
    @(negedge clk);
    check("sim_done_pulse", 32'(init_done), 32'd0);
    check("sim_acc_cs", 32'(mem_cs_), 32'(CS_ENABLE));
    check("sim_acc_addr", 32'(mem_addr), 32'h05);
    @(negedge clk);
    check("sim_ack", 32'(ack), 32'd1);
    check("sim_rvalid", 32'(rvalid), 32'd1);
    check("sim_rdata", rdata, 32'd0);
    req = 1'b0;
    rd_exp = '0;
    n_access++;
    @(negedge clk);

    for (int k = 0; k < 120; k++)
      model_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), $urandom);

    // Held req: read then write with req never dropping through RESP.
    model_access(1'b1, 8'h21, 32'hA5A5_0021);
    model_access(1'b1, 8'h22, 32'h5A5A_0022);
    req = 1'b1; we = 1'b0; addr = 8'h21;
    @(negedge clk);
    check("held_acc1_cs", 32'(mem_cs_), 32'(CS_ENABLE));
    @(negedge clk);
    check("held_ack1", 32'(ack), 32'd1);
    check("held_rdata1", rdata, 32'hA5A5_0021);
    we = 1'b1; addr = 8'h22; wdata = 32'h1234_5678;
    @(negedge clk);
    check("held_gap_cs", 32'(mem_cs_), 32'(CS_DISABLE));
    check("held_gap_ack", 32'(ack), 32'd0);
    @(negedge clk);
    check("held_acc2_cs", 32'(mem_cs_), 32'(CS_ENABLE));
    check("held_acc2_rw", 32'(mem_rw_), 32'(RW_WRITE));
    @(negedge clk);
    check("held_ack2", 32'(ack), 32'd1);
    check("held_rvalid2", 32'(rvalid), 32'd0);
    check("held_rdata2", rdata, 32'hA5A5_0021);
    req = 1'b0; we = 1'b0;
    rm[8'h22] = 32'h1234_5678;
    rd_exp = 32'hA5A5_0021;
    n_access += 2;
    @(negedge clk);
    model_access(1'b0, 8'h22, '0);

    // init_start while ACCESS is in flight must be dropped.
    req = 1'b1; we = 1'b0; addr = 8'h21;
    @(negedge clk);
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    check("ign_ack", 32'(ack), 32'd1);
    req = 1'b0;
    n_access++;
    rd_exp = rm[8'h21];
    @(negedge clk);
    check("ign_busy", 32'(busy), 32'd0);
    en = 0;
    for (int k = 0; k < 6; k++) begin
      if (mem_cs_ == CS_ENABLE || busy) en++;
      @(negedge clk);
    end
    check("ign_no_init", 32'(en), 32'd0);

    // Reset in the middle of a sweep.
    for (int a = 8'h3E; a <= 8'h42; a++) model_access(1'b1, AW'(a), 32'h1000 + 32'(a));
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    repeat (8'h40) @(negedge clk);
    check("abort_addr", 32'(mem_addr), 32'h40);
    reset_ = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cs", 32'(mem_cs_), 32'(CS_DISABLE));
    check("abort_rdata", rdata, 32'd0);
    en = 0;
    for (int k = 0; k < 5; k++) begin
      if (init_done || mem_cs_ == CS_ENABLE) en++;
      @(negedge clk);
    end
    check("abort_quiet", 32'(en), 32'd0);
    for (int a = 0; a <= 8'h40; a++) rm[a] = INIT_V;
    rd_exp = '0;
    model_access(1'b0, 8'h3F, '0);
    model_access(1'b0, 8'h40, '0);
    model_access(1'b0, 8'h41, '0);
    model_access(1'b0, 8'h42, '0);

    run_sweep();
    @(negedge clk);
    check("restart_done_pulse", 32'(init_done), 32'd0);
    model_access(1'b0, 8'h41, '0);

    repeat (2) @(negedge clk);
    check("ack_count", 32'(ack_seen), 32'(n_access));
    check("handshake_invariants", 32'(bad_inv), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
